// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/interrupt sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_ISSUE    = 2'd3
  } ctrl_state_t;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;
  localparam logic [1:0] PC_SEL_IRQ = 2'b11;

  // Width of the drain counter; at least one bit even for a single drain cycle.
  function automatic int drain_cnt_w(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: load in EX writes a register the ID instruction reads.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result feeds the stall decision in the sequencer.
module load_use_detect (
  input  logic       ex_memrd,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rt,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  // $0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign rs_hit   = (ex_rt == id_rs);
  assign rt_hit   = id_use_rt && (ex_rt == id_rt);
  assign load_use = ex_memrd && (ex_rt != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stalls, flushes, memory freeze and interrupt entry.
// Latency: control outputs are combinational from state and inputs; IRQ redirect after DRAIN_CYC drain cycles.
// Backpressure: mem_busy freezes the back end and holds PC/IF-ID; it also pauses the IRQ drain count.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             id_use_rt,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic             id_jump,
  input  logic             id_ex_memrd,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_branch_tk,
  input  logic             mem_busy,
  input  logic             irq,
  input  logic             irq_en,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_hazard,
  output logic             id_ex_special,
  output logic             pipe_freeze,
  output logic [31:0]      epc_out,
  output logic             epc_we,
  output logic             irq_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int             DCW        = drain_cnt_w(DRAIN_CYC);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

  ctrl_state_t    state;
  ctrl_state_t    state_nxt;
  logic [DCW-1:0] drain_cnt;
  logic [DCW-1:0] drain_cnt_nxt;
  logic           epc_load;
  logic           stall_evt;
  logic           flush_evt;
  logic           load_use;
  logic           irq_take;

  load_use_detect u_load_use (
    .ex_memrd  (id_ex_memrd),
    .ex_rt     (id_ex_rt),
    .id_rs     (if_id_rs),
    .id_rt     (if_id_rt),
    .id_use_rt (id_use_rt),
    .load_use  (load_use)
  );

  // An interrupt is only taken against a real instruction that is not being flushed.
  assign irq_take = irq && irq_en && id_valid && !ex_branch_tk;

  // Decode: pipeline controls, next state and counter events for this cycle.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    epc_load      = 1'b0;
    stall_evt     = 1'b0;
    flush_evt     = 1'b0;
    pc_write      = 1'b1;
    pc_sel        = PC_SEL_SEQ;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_hazard  = 1'b0;
    id_ex_special = 1'b0;
    pipe_freeze   = 1'b0;
    epc_we        = 1'b0;
    irq_ack       = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_freeze = 1'b1;
          state_nxt   = ST_MEM_WAIT;
        end else if (irq_take) begin
          // The ID instruction is squashed and replayed from EPC after the handler.
          pc_write      = 1'b0;
          if_id_flush   = 1'b1;
          id_ex_special = 1'b1;
          epc_load      = 1'b1;
          drain_cnt_nxt = '0;
          state_nxt     = ST_DRAIN;
        end else if (ex_branch_tk) begin
          pc_sel        = PC_SEL_BR;
          if_id_flush   = 1'b1;
          id_ex_special = 1'b1;
          flush_evt     = 1'b1;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_hazard = 1'b1;
          stall_evt    = 1'b1;
        end else if (id_jump) begin
          pc_sel      = PC_SEL_JMP;
          if_id_flush = 1'b1;
          flush_evt   = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_freeze = 1'b1;
        if (!mem_busy) begin
          state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        pc_write      = 1'b0;
        if_id_flush   = 1'b1;
        id_ex_special = 1'b1;
        if (mem_busy) begin
          pipe_freeze = 1'b1;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_nxt = ST_ISSUE;
        end else begin
          drain_cnt_nxt = drain_cnt + 1'b1;
        end
      end
      ST_ISSUE: begin
        pc_sel      = PC_SEL_IRQ;
        if_id_flush = 1'b1;
        epc_we      = 1'b1;
        irq_ack     = 1'b1;
        state_nxt   = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Sequencer state, drain progress and the captured exception PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      epc_out   <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (epc_load) begin
        epc_out <= id_pc;
      end
    end
  end

  // Event counters saturate at all-ones so long runs never alias back to small values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_evt && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic vs a reference model.
// Latency: outputs sampled 2 time units after each rising edge.
// Backpressure: mem_busy is driven as part of the stimulus.
module tb_pipe_hazard_ctrl;

  localparam int     DRAIN_CYC = 3;
  localparam int     CNT_W     = 16;
  localparam longint CNT_MAX   = (64'd1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic             id_use_rt;
  logic             id_valid;
  logic [31:0]      id_pc;
  logic             id_jump;
  logic             id_ex_memrd;
  logic [4:0]       id_ex_rt;
  logic             ex_branch_tk;
  logic             mem_busy;
  logic             irq;
  logic             irq_en;
  logic             pc_write;
  logic [1:0]       pc_sel;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_hazard;
  logic             id_ex_special;
  logic             pipe_freeze;
  logic [31:0]      epc_out;
  logic             epc_we;
  logic             irq_ack;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .id_use_rt     (id_use_rt),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_jump       (id_jump),
    .id_ex_memrd   (id_ex_memrd),
    .id_ex_rt      (id_ex_rt),
    .ex_branch_tk  (ex_branch_tk),
    .mem_busy      (mem_busy),
    .irq           (irq),
    .irq_en        (irq_en),
    .pc_write      (pc_write),
    .pc_sel        (pc_sel),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_hazard  (id_ex_hazard),
    .id_ex_special (id_ex_special),
    .pipe_freeze   (pipe_freeze),
    .epc_out       (epc_out),
    .epc_we        (epc_we),
    .irq_ack       (irq_ack),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: behaviour described as "frozen on memory", "N drain cycles left",
  // "redirect due", plus unbounded event totals clipped only when compared.
  bit          m_frozen;
  int          m_left;
  bit          m_issue;
  longint      m_stall;
  longint      m_flush;
  logic [31:0] m_epc;
  bit          nx_frozen;
  int          nx_left;
  bit          nx_issue;
  longint      nx_stall;
  longint      nx_flush;
  logic [31:0] nx_epc;
  bit          nx_valid;

  logic        e_pc_write, e_if_id_write, e_if_id_flush, e_hazard, e_special;
  logic        e_freeze, e_epc_we, e_ack;
  logic [1:0]  e_pc_sel;

  function automatic longint sat(input longint v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic model_reset();
    m_frozen = 0; m_left = 0; m_issue = 0;
    m_stall = 0; m_flush = 0; m_epc = '0;
    nx_valid = 0;
  endtask

  task automatic idle_inputs();
    if_id_rs = 5'd1; if_id_rt = 5'd2; id_use_rt = 1'b0; id_valid = 1'b1;
    id_pc = 32'h0040_0000; id_jump = 1'b0; id_ex_memrd = 1'b0; id_ex_rt = 5'd0;
    ex_branch_tk = 1'b0; mem_busy = 1'b0; irq = 1'b0; irq_en = 1'b0;
  endtask

  // Advance to just after the next rising edge and retire the model's pending update.
  task automatic step();
    @(posedge clk);
    #1;
    if (nx_valid) begin
      m_frozen = nx_frozen; m_left = nx_left; m_issue = nx_issue;
      m_stall = nx_stall; m_flush = nx_flush; m_epc = nx_epc;
      nx_valid = 0;
    end
  endtask

  // Let inputs settle, then predict this cycle's outputs and what the next edge will commit.
  task automatic eval();
    bit lu;
    #1;
    lu = id_ex_memrd && (id_ex_rt != 5'd0) &&
         ((id_ex_rt == if_id_rs) || (id_use_rt && (id_ex_rt == if_id_rt)));
    e_pc_write = 1; e_pc_sel = 2'b00; e_if_id_write = 1; e_if_id_flush = 0;
    e_hazard = 0; e_special = 0; e_freeze = 0; e_epc_we = 0; e_ack = 0;
    nx_frozen = m_frozen; nx_left = m_left; nx_issue = m_issue;
    nx_stall = m_stall; nx_flush = m_flush; nx_epc = m_epc;
    if (m_issue) begin
      e_pc_sel = 2'b11; e_if_id_flush = 1; e_epc_we = 1; e_ack = 1;
      nx_issue = 0;
    end else if (m_left > 0) begin
      e_pc_write = 0; e_if_id_flush = 1; e_special = 1;
      if (mem_busy) e_freeze = 1;
      else begin
        nx_left = m_left - 1;
        if (nx_left == 0) nx_issue = 1;
      end
    end else if (m_frozen) begin
      e_pc_write = 0; e_if_id_write = 0; e_freeze = 1;
      nx_frozen = mem_busy;
    end else if (mem_busy) begin
      e_pc_write = 0; e_if_id_write = 0; e_freeze = 1;
      nx_frozen = 1;
    end else if (irq && irq_en && id_valid && !ex_branch_tk) begin
      e_pc_write = 0; e_if_id_flush = 1; e_special = 1;
      nx_left = DRAIN_CYC; nx_epc = id_pc;
    end else if (ex_branch_tk) begin
      e_pc_sel = 2'b01; e_if_id_flush = 1; e_special = 1;
      nx_flush = m_flush + 1;
    end else if (lu) begin
      e_pc_write = 0; e_if_id_write = 0; e_hazard = 1;
      nx_stall = m_stall + 1;
    end else if (id_jump) begin
      e_pc_sel = 2'b10; e_if_id_flush = 1;
      nx_flush = m_flush + 1;
    end
    nx_valid = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    eval();
    checks++;
    if (pc_write !== 1'b1 || if_id_write !== 1'b1 || pc_sel !== 2'b00) begin
      errors++;
      $display("FAIL reset_run_ctrl got pc_write=%b if_id_write=%b pc_sel=%b want 1 1 00",
               pc_write, if_id_write, pc_sel);
    end
    checks++;
    if ({if_id_flush, id_ex_hazard, id_ex_special, pipe_freeze, epc_we, irq_ack} !== 6'b0) begin
      errors++;
      $display("FAIL reset_quiet_outputs got %b want 000000",
               {if_id_flush, id_ex_hazard, id_ex_special, pipe_freeze, epc_we, irq_ack});
    end
    checks++;
    if (epc_out !== 32'h0 || stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++;
      $display("FAIL reset_regs got epc=%h stall=%0d flush=%0d want 0 0 0",
               epc_out, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    step(); idle_inputs();
    id_ex_memrd = 1'b1; id_ex_rt = 5'd2; if_id_rs = 5'd2; if_id_rt = 5'd3;
    eval();
    checks++;
    if (pc_write !== 1'b0 || if_id_write !== 1'b0 || id_ex_hazard !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall got pc_write=%b if_id_write=%b hazard=%b want 0 0 1",
               pc_write, if_id_write, id_ex_hazard);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL load_use_cnt_before got %0d want 0", stall_cnt);
    end
    step(); idle_inputs(); eval();
    checks++;
    if (stall_cnt !== 16'd1 || id_ex_hazard !== 1'b0 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL load_use_after got stall_cnt=%0d hazard=%b pc_write=%b want 1 0 1",
               stall_cnt, id_ex_hazard, pc_write);
    end
  endtask

  task automatic test_no_stall();
    step(); idle_inputs();
    id_ex_memrd = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
    eval();
    checks++;
    if (id_ex_hazard !== 1'b0 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL load_r0_no_stall got hazard=%b pc_write=%b want 0 1", id_ex_hazard, pc_write);
    end
    step(); idle_inputs();
    id_ex_memrd = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd1; if_id_rt = 5'd5; id_use_rt = 1'b0;
    eval();
    checks++;
    if (id_ex_hazard !== 1'b0) begin
      errors++;
      $display("FAIL rt_unused_no_stall got hazard=%b want 0", id_ex_hazard);
    end
    step();
    id_use_rt = 1'b1;
    eval();
    checks++;
    if (id_ex_hazard !== 1'b1 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL rt_used_stall got hazard=%b pc_write=%b want 1 0", id_ex_hazard, pc_write);
    end
  endtask

  task automatic test_branch_lu();
    longint s0, f0;
    step(); idle_inputs();
    s0 = m_stall; f0 = m_flush;
    ex_branch_tk = 1'b1; id_ex_memrd = 1'b1; id_ex_rt = 5'd7; if_id_rs = 5'd7;
    eval();
    checks++;
    if (pc_sel !== 2'b01 || id_ex_special !== 1'b1 || id_ex_hazard !== 1'b0 ||
        pc_write !== 1'b1 || if_id_flush !== 1'b1) begin
      errors++;
      $display("FAIL branch_over_lu got pc_sel=%b special=%b hazard=%b pc_write=%b flush=%b want 01 1 0 1 1",
               pc_sel, id_ex_special, id_ex_hazard, pc_write, if_id_flush);
    end
    step(); idle_inputs();
    id_jump = 1'b1;
    eval();
    checks++;
    if (pc_sel !== 2'b10 || if_id_flush !== 1'b1 || id_ex_special !== 1'b0 ||
        stall_cnt !== 16'(s0) || flush_cnt !== 16'(f0 + 1)) begin
      errors++;
      $display("FAIL jump_and_counts got pc_sel=%b flush=%b special=%b stall=%0d flushc=%0d want 10 1 0 %0d %0d",
               pc_sel, if_id_flush, id_ex_special, stall_cnt, flush_cnt, s0, f0 + 1);
    end
    step(); idle_inputs(); eval();
    checks++;
    if (flush_cnt !== 16'(f0 + 2)) begin
      errors++;
      $display("FAIL jump_flush_cnt got %0d want %0d", flush_cnt, f0 + 2);
    end
  endtask

  task automatic test_mem_wait();
    step(); idle_inputs();
    mem_busy = 1'b1; ex_branch_tk = 1'b1;
    eval();
    checks++;
    if (pipe_freeze !== 1'b1 || pc_write !== 1'b0 || if_id_write !== 1'b0 || id_ex_special !== 1'b0) begin
      errors++;
      $display("FAIL mem_busy_first got freeze=%b pc_write=%b if_id_write=%b special=%b want 1 0 0 0",
               pipe_freeze, pc_write, if_id_write, id_ex_special);
    end
    step(); idle_inputs(); mem_busy = 1'b1; eval();
    checks++;
    if (pipe_freeze !== 1'b1 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL mem_busy_hold got freeze=%b pc_write=%b want 1 0", pipe_freeze, pc_write);
    end
    step(); idle_inputs(); eval();
    step(); idle_inputs(); eval();
    checks++;
    if (pipe_freeze !== 1'b0 || pc_write !== 1'b1 || if_id_write !== 1'b1) begin
      errors++;
      $display("FAIL mem_wait_release got freeze=%b pc_write=%b if_id_write=%b want 0 1 1",
               pipe_freeze, pc_write, if_id_write);
    end
  endtask

  // busy_at: drain cycle index (0-based) where a 2-cycle mem_busy burst starts; -1 for none.
  task automatic test_irq(input int busy_at);
    int drain_seen;
    int busy_left;
    step(); idle_inputs();
    irq = 1'b1; irq_en = 1'b1; id_pc = 32'h0040_0010;
    eval();
    checks++;
    if (pc_write !== 1'b0 || irq_ack !== 1'b0) begin
      errors++;
      $display("FAIL irq_entry got pc_write=%b ack=%b want 0 0", pc_write, irq_ack);
    end
    drain_seen = 0;
    busy_left = 0;
    for (int c = 0; c < DRAIN_CYC + 2; c++) begin
      step();
      id_pc = 32'h0040_0020;
      if (c == busy_at) busy_left = 2;
      mem_busy = (busy_left > 0);
      eval();
      if (busy_left > 0) begin
        busy_left--;
        checks++;
        if (pipe_freeze !== 1'b1 || irq_ack !== 1'b0) begin
          errors++;
          $display("FAIL drain_busy_freeze got freeze=%b ack=%b want 1 0", pipe_freeze, irq_ack);
        end
      end else if (drain_seen < DRAIN_CYC) begin
        drain_seen++;
        checks++;
        if (pc_write !== 1'b0 || id_ex_special !== 1'b1 || if_id_flush !== 1'b1 || irq_ack !== 1'b0) begin
          errors++;
          $display("FAIL drain_cycle got pc_write=%b special=%b flush=%b ack=%b want 0 1 1 0",
                   pc_write, id_ex_special, if_id_flush, irq_ack);
        end
      end
      if (drain_seen == DRAIN_CYC && busy_left == 0 && mem_busy == 1'b0) break;
    end
    step(); idle_inputs(); irq = 1'b1; irq_en = 1'b1; eval();
    checks++;
    if (pc_sel !== 2'b11 || pc_write !== 1'b1 || irq_ack !== 1'b1 || epc_we !== 1'b1 ||
        epc_out !== 32'h0040_0010) begin
      errors++;
      $display("FAIL irq_issue got pc_sel=%b pc_write=%b ack=%b epc_we=%b epc=%h want 11 1 1 1 00400010",
               pc_sel, pc_write, irq_ack, epc_we, epc_out);
    end
    step(); idle_inputs(); eval();
    checks++;
    if (irq_ack !== 1'b0 || pc_sel !== 2'b00 || epc_we !== 1'b0) begin
      errors++;
      $display("FAIL irq_after_issue got ack=%b pc_sel=%b epc_we=%b want 0 00 0", irq_ack, pc_sel, epc_we);
    end
  endtask

  task automatic test_irq_defer();
    int acks;
    step(); idle_inputs();
    irq = 1'b1; irq_en = 1'b1; ex_branch_tk = 1'b1; id_pc = 32'h0000_1000;
    eval();
    checks++;
    if (pc_sel !== 2'b01 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL irq_defer_branch got pc_sel=%b pc_write=%b want 01 1", pc_sel, pc_write);
    end
    step(); ex_branch_tk = 1'b0; id_valid = 1'b0; eval();
    checks++;
    if (pc_write !== 1'b1 || id_ex_special !== 1'b0) begin
      errors++;
      $display("FAIL irq_defer_bubble got pc_write=%b special=%b want 1 0", pc_write, id_ex_special);
    end
    step(); id_valid = 1'b1; id_pc = 32'h0000_2000; eval();
    checks++;
    if (pc_write !== 1'b0 || id_ex_special !== 1'b1) begin
      errors++;
      $display("FAIL irq_deferred_taken got pc_write=%b special=%b want 0 1", pc_write, id_ex_special);
    end
    acks = 0;
    for (int c = 0; c < DRAIN_CYC + 3; c++) begin
      step(); idle_inputs(); eval();
      if (irq_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 1 || epc_out !== 32'h0000_2000) begin
      errors++;
      $display("FAIL irq_defer_ack got acks=%0d epc=%h want 1 00002000", acks, epc_out);
    end
  endtask

  task automatic test_random(input int n);
    step();
    for (int c = 0; c < n; c++) begin
      if (c != 0) step();
      if_id_rs     = 5'($urandom_range(0, 3));
      if_id_rt     = 5'($urandom_range(0, 3));
      id_ex_rt     = 5'($urandom_range(0, 3));
      id_use_rt    = ($urandom_range(0, 1) == 1);
      id_ex_memrd  = ($urandom_range(0, 2) == 0);
      ex_branch_tk = ($urandom_range(0, 5) == 0);
      id_jump      = ($urandom_range(0, 5) == 0);
      mem_busy     = ($urandom_range(0, 7) == 0);
      irq          = ($urandom_range(0, 9) == 0);
      irq_en       = ($urandom_range(0, 1) == 1);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_pc        = $urandom;
      eval();
      checks++;
      if ({pc_write, pc_sel, if_id_write, if_id_flush} !== {e_pc_write, e_pc_sel, e_if_id_write, e_if_id_flush}) begin
        errors++;
        $display("FAIL rand_front cyc=%0d got %b want %b", c,
                 {pc_write, pc_sel, if_id_write, if_id_flush},
                 {e_pc_write, e_pc_sel, e_if_id_write, e_if_id_flush});
      end
      checks++;
      if ({id_ex_hazard, id_ex_special, pipe_freeze, epc_we, irq_ack} !== {e_hazard, e_special, e_freeze, e_epc_we, e_ack}) begin
        errors++;
        $display("FAIL rand_back cyc=%0d got %b want %b", c,
                 {id_ex_hazard, id_ex_special, pipe_freeze, epc_we, irq_ack},
                 {e_hazard, e_special, e_freeze, e_epc_we, e_ack});
      end
      checks++;
      if (epc_out !== m_epc || stall_cnt !== 16'(sat(m_stall)) || flush_cnt !== 16'(sat(m_flush))) begin
        errors++;
        $display("FAIL rand_regs cyc=%0d got epc=%h stall=%0d flush=%0d want %h %0d %0d", c,
                 epc_out, stall_cnt, flush_cnt, m_epc, sat(m_stall), sat(m_flush));
      end
    end
  endtask

  task automatic test_reset_drain();
    int acks;
    step(); idle_inputs(); irq = 1'b1; irq_en = 1'b1; id_pc = 32'h0000_3000; eval();
    step(); idle_inputs(); eval();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pc_write !== 1'b1 || id_ex_special !== 1'b0 || if_id_flush !== 1'b0 ||
        epc_out !== 32'h0 || stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid_drain got pc_write=%b special=%b flush=%b epc=%h stall=%0d flushc=%0d want 1 0 0 0 0 0",
               pc_write, id_ex_special, if_id_flush, epc_out, stall_cnt, flush_cnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    eval();
    acks = 0;
    for (int c = 0; c < DRAIN_CYC + 3; c++) begin
      step(); idle_inputs(); eval();
      if (irq_ack === 1'b1 || pc_write !== 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL reset_drain_no_ack got %0d non-idle cycles want 0", acks);
    end
  endtask

  task automatic test_saturate();
    step(); idle_inputs();
    id_ex_memrd = 1'b1; id_ex_rt = 5'd9; if_id_rs = 5'd9;
    eval();
    for (int c = 0; c < 65540; c++) begin
      step(); eval();
    end
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL stall_saturate got %h want ffff", stall_cnt);
    end
    step(); eval();
    checks++;
    if (stall_cnt !== 16'hFFFF || id_ex_hazard !== 1'b1) begin
      errors++;
      $display("FAIL stall_stays_max got %h hazard=%b want ffff 1", stall_cnt, id_ex_hazard);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_lu();
    test_mem_wait();
    test_irq(-1);
    test_irq(1);
    test_irq_defer();
    test_random(3000);
    test_reset_drain();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
